pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher.sv | 80 ++++++++
 tb/tb_pulse_stretcher.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches single-cycle event requests into fixed-length high periods
//   with a guaranteed minimum low gap, queuing up to 2^PEND_WIDTH-1 further requests.
// Ports:
//   clk      - single clock, all logic on rising edge
//   rst      - synchronous active-high reset; aborts any pulse and discards queued events
//   in       - event request, every cycle with in=1 is one event
//   out      - registered stretched level, high for ON_CYCLES per event
//   busy     - high whenever the block is not idle
//   pending  - queued events that have not started their high period yet
//   overflow - sticky, set when an event is dropped because the queue is full
module pulse_stretcher #(
    parameter int COUNT_WIDTH = 20,
    parameter int ON_CYCLES   = 480000,
    parameter int OFF_CYCLES  = 480000,
    parameter int PEND_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in,
    output logic                  out,
    output logic                  busy,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_e;
    localparam logic [COUNT_WIDTH-1:0] ON_LAST  = COUNT_WIDTH'(ON_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] OFF_LAST = COUNT_WIDTH'(OFF_CYCLES - 1);
    localparam logic [PEND_WIDTH-1:0]  PEND_MAX = '1;
    state_e                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PEND_WIDTH-1:0]   pending_q, pending_d;
    logic                    overflow_q, overflow_d;
    logic                    out_q, out_d;
    logic                    last_on, last_gap;
    logic                    evt, take, full;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
        end
    end
    always_comb begin
        last_on  = state_q == ON && cnt_q == ON_LAST;
        last_gap = state_q == GAP && cnt_q == OFF_LAST;
        state_d  = state_q == IDLE ? (in ? ON : IDLE) :
                   state_q == ON   ? (last_on ? GAP : ON) :
                   state_q == GAP  ? (last_gap ? ((pending_q != '0 || in) ? ON : IDLE) : GAP) :
                                     IDLE;
        // counter restarts on every state entry and stays parked at 0 while idle
        cnt_d    = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
    end
    always_comb begin
        // an in=1 on the last gap cycle with nothing queued starts the next pulse directly
        evt        = in && state_q != IDLE && !(last_gap && pending_q == '0);
        take       = last_gap && pending_q != '0;
        full       = pending_q == PEND_MAX;
        pending_d  = (evt && !take && !full) ? pending_q + 1'b1 :
                     (take && !evt)          ? pending_q - 1'b1 :
                                               pending_q;
        overflow_d = overflow_q | (evt && !take && full);
        out_d      = state_d == ON;
        busy       = state_q != IDLE;
    end
    assign out      = out_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: scoreboard bench for pulse_stretcher against a schedule-based model
module tb_pulse_stretcher;
    localparam int ON = 4, OFF = 3, PMAX = 3;
    logic clk = 1'b0, rst = 1'b1, in = 1'b0, out, busy, overflow;
    logic [1:0] pending;
    logic rst_m = 1'b1, in_m = 1'b0, out_m, busy_m, ovf_m;
    logic [1:0] pend_m;
    int cyc = 0;
    int n_chk = 0, n_fail = 0;
    typedef struct {int cyc; bit o; bit b; int p; bit v;} exp_t;
    typedef struct {int t; int s;} ev_t;
    exp_t q[$], qm[$];
    ev_t evs[$];
    int last_s = -1000;
    bit m_ovf = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    pulse_stretcher #(.COUNT_WIDTH(4), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .PEND_WIDTH(2)) u_dut (
        .clk(clk), .rst(rst), .in(in), .out(out), .busy(busy), .pending(pending), .overflow(overflow)
    );
    pulse_stretcher #(.COUNT_WIDTH(2), .ON_CYCLES(1), .OFF_CYCLES(1), .PEND_WIDTH(2)) u_min (
        .clk(clk), .rst(rst_m), .in(in_m), .out(out_m), .busy(busy_m), .pending(pend_m), .overflow(ovf_m)
    );
    task automatic chk(string nm, int act, int exp, int c);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, c, act, exp);
        end
    endtask
    // Model: each accepted event owns a start cycle; a pulse is high for ON cycles from its
    // start and keeps the block busy for ON+OFF cycles. Events start one cycle after request
    // or as soon as the previous pulse's gap has elapsed, whichever is later.
    task automatic step(bit r, bit i);
        int c, nxt, cnt;
        exp_t e;
        c = cyc;
        rst = r;
        in = i;
        if (r) begin
            evs.delete();
            last_s = -1000;
            m_ovf = 1'b0;
        end else if (i) begin
            nxt = (c + 1 > last_s + ON + OFF) ? c + 1 : last_s + ON + OFF;
            cnt = 0;
            foreach (evs[k]) if (evs[k].s > c + 1) cnt++;
            if (nxt > c + 1 && cnt >= PMAX) m_ovf = 1'b1;
            else begin
                evs.push_back('{c, nxt});
                last_s = nxt;
            end
        end
        e.cyc = c + 1; e.o = 1'b0; e.b = 1'b0; e.p = 0; e.v = m_ovf;
        foreach (evs[k]) begin
            if (evs[k].s <= c + 1 && c + 1 < evs[k].s + ON) e.o = 1'b1;
            if (evs[k].s <= c + 1 && c + 1 < evs[k].s + ON + OFF) e.b = 1'b1;
            if (evs[k].t + 1 <= c + 1 && c + 1 < evs[k].s) e.p++;
        end
        while (evs.size() > 0 && evs[0].s + ON + OFF < c + 1) void'(evs.pop_front());
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("out", int'(out), int'(e.o), cyc);
            chk("busy", int'(busy), int'(e.b), cyc);
            chk("pending", int'(pending), e.p, cyc);
            chk("overflow", int'(overflow), int'(e.v), cyc);
        end
        if (qm.size() > 0 && qm[0].cyc == cyc) begin
            e = qm.pop_front();
            chk("min_out", int'(out_m), int'(e.o), cyc);
            chk("min_busy", int'(busy_m), int'(e.b), cyc);
            chk("min_pending", int'(pend_m), e.p, cyc);
            chk("min_overflow", int'(ovf_m), int'(e.v), cyc);
        end
    end
    initial begin
        int p, len, c0;
        bit mo[5] = '{1, 0, 1, 0, 0};
        bit mb[5] = '{1, 1, 1, 1, 0};
        int mp[5] = '{0, 1, 0, 0, 0};
        repeat (3) step(1'b1, 1'b0);
        rst_m = 1'b0;
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1);
        repeat (16) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b1);
        repeat (40) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1);
        repeat (45) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b0);
        repeat (30) begin
            p = $urandom_range(0, 60);
            len = $urandom_range(5, 60);
            repeat (len) step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < p);
            repeat ($urandom_range(0, 10)) step(1'b0, 1'b0);
        end
        repeat (40) step(1'b0, 1'b0);
        c0 = cyc;
        for (int k = 0; k < 5; k++) qm.push_back('{c0 + 1 + k, mo[k], mb[k], mp[k], 1'b0});
        in_m = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        in_m = 1'b0;
        repeat (6) step(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("drain", q.size() + qm.size(), 0, cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
